// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable UART receiver (5-9 data bits, none/odd/even parity, 1-2 stop bits).
// Optional break detection is enabled by defining UART_RX_BREAK_DETECT_EN.
`default_nettype none

module uart_rx_cfg #(
    parameter int CLKS_PER_BIT = 87,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset,
    input  logic                 i_Rx_Serial,
    output logic                 o_Rx_DV,
    output logic [DATA_BITS-1:0] o_Rx_Data,
    output logic                 o_Parity_Err,
    output logic                 o_Frame_Err,
    output logic                 o_Busy,
    output logic                 o_Break
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam int HALF  = (CLKS_PER_BIT - 1) / 2;

    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(HALF);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);
    localparam logic             LAST_STOP = 1'(STOP_BITS - 1);
    localparam logic             PAR_EN   = (PARITY_MODE != 0);
    localparam logic             PAR_ODD  = (PARITY_MODE == 1);

    if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_parity
        $error("uart_rx_cfg: PARITY_MODE must be 0, 1 or 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_rx_cfg: DATA_BITS must be 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_rx_cfg: STOP_BITS must be 1 or 2");
    end
    if (CLKS_PER_BIT < 4 || CLKS_PER_BIT > 65535) begin : g_bad_clks
        $error("uart_rx_cfg: CLKS_PER_BIT must be 4..65535");
    end

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        PARITY  = 3'd3,
        STOP    = 3'd4,
        DONE    = 3'd5,
        CLEANUP = 3'd6
`ifdef UART_RX_BREAK_DETECT_EN
        , BREAK_WAIT = 3'd7
`endif
    } state_t;

    state_t               state;
    logic                 sync_1;
    logic                 rx_s;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     idx;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic                 frame_err_acc;

`ifdef UART_RX_BREAK_DETECT_EN
    logic first_stop;
    logic is_break;
    assign is_break = (shreg == '0) && (!PAR_EN || !par_bit) && !first_stop;
`else
    assign o_Break = 1'b0;
`endif

    // Pin is asynchronous; the idle-high reset value avoids a false start after reset.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            sync_1 <= 1'b1;
            rx_s   <= 1'b1;
        end else begin
            sync_1 <= i_Rx_Serial;
            rx_s   <= sync_1;
        end
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state         <= IDLE;
            cnt           <= '0;
            idx           <= '0;
            stop_idx      <= 1'b0;
            shreg         <= '0;
            par_bit       <= 1'b0;
            frame_err_acc <= 1'b0;
            o_Rx_DV       <= 1'b0;
            o_Rx_Data     <= '0;
            o_Parity_Err  <= 1'b0;
            o_Frame_Err   <= 1'b0;
            o_Busy        <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
            first_stop    <= 1'b1;
            o_Break       <= 1'b0;
`endif
        end else begin
            o_Rx_DV <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
            o_Break <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    cnt           <= '0;
                    idx           <= '0;
                    stop_idx      <= 1'b0;
                    frame_err_acc <= 1'b0;
                    if (!rx_s) begin
                        state  <= START;
                        o_Busy <= 1'b1;
                    end
                end
                START: begin
                    if (cnt == HALF_CNT) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            state <= DATA;
                        end else begin
                            state  <= IDLE;
                            o_Busy <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (cnt == LAST_CNT) begin
                        cnt        <= '0;
                        shreg[idx] <= rx_s;
                        if (idx == LAST_IDX) begin
                            idx   <= '0;
                            state <= PAR_EN ? PARITY : STOP;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                PARITY: begin
                    if (cnt == LAST_CNT) begin
                        cnt     <= '0;
                        par_bit <= rx_s;
                        state   <= STOP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (cnt == LAST_CNT) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            frame_err_acc <= 1'b1;
                        end
`ifdef UART_RX_BREAK_DETECT_EN
                        if (!stop_idx) begin
                            first_stop <= rx_s;
                        end
`endif
                        if (stop_idx == LAST_STOP) begin
                            state <= DONE;
                        end else begin
                            stop_idx <= stop_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    o_Rx_DV      <= 1'b1;
                    o_Rx_Data    <= shreg;
                    o_Parity_Err <= PAR_EN && ((^shreg ^ par_bit) != PAR_ODD);
`ifdef UART_RX_BREAK_DETECT_EN
                    o_Frame_Err  <= frame_err_acc | is_break;
                    if (is_break) begin
                        o_Break <= 1'b1;
                        state   <= BREAK_WAIT;
                    end else begin
                        state <= CLEANUP;
                    end
`else
                    o_Frame_Err  <= frame_err_acc;
                    state        <= CLEANUP;
`endif
                end
                CLEANUP: begin
                    state  <= IDLE;
                    o_Busy <= 1'b0;
                end
`ifdef UART_RX_BREAK_DETECT_EN
                // Start detection is suppressed until the line returns high.
                BREAK_WAIT: begin
                    if (rx_s) begin
                        state  <= IDLE;
                        o_Busy <= 1'b0;
                    end
                end
`endif
                default: begin
                    state  <= IDLE;
                    o_Busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: scoreboard bench for uart_rx_cfg in 8N1, 7E1 and 8O2 configurations.
`default_nettype none

module tb_uart_rx_cfg;

    localparam int CPB  = 16;
    localparam int HALF = (CPB - 1) / 2;
`ifdef UART_RX_BREAK_DETECT_EN
    localparam logic BRK_EXP = 1'b1;
`else
    localparam logic BRK_EXP = 1'b0;
`endif

    typedef logic [11:0] exp_t;   // {break, frame_err, parity_err, data[8:0]}

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx0 = 1'b1, rx1 = 1'b1, rx2 = 1'b1;

    logic       dv0, perr0, ferr0, busy0, brk0;
    logic [7:0] d0;
    logic       dv1, perr1, ferr1, busy1, brk1;
    logic [6:0] d1;
    logic       dv2, perr2, ferr2, busy2, brk2;
    logic [7:0] d2;

    always #5 clk = ~clk;

    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u_8n1 (
        .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx0), .o_Rx_DV(dv0), .o_Rx_Data(d0),
        .o_Parity_Err(perr0), .o_Frame_Err(ferr0), .o_Busy(busy0), .o_Break(brk0));

    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(1)) u_7e1 (
        .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx1), .o_Rx_DV(dv1), .o_Rx_Data(d1),
        .o_Parity_Err(perr1), .o_Frame_Err(ferr1), .o_Busy(busy1), .o_Break(brk1));

    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(2)) u_8o2 (
        .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx2), .o_Rx_DV(dv2), .o_Rx_Data(d2),
        .o_Parity_Err(perr2), .o_Frame_Err(ferr2), .o_Busy(busy2), .o_Break(brk2));

    int   n_assert = 0;
    int   n_fail   = 0;
    exp_t q0[$], q1[$], q2[$];
    exp_t e0, e1, e2;
    int   dv_cnt0 = 0;
    logic busy_chk0 = 1'b0;
    logic hold = 1'b0;
    int   hold_cnt = 0;
    exp_t hold_first = '0;
    int   saved;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t pack(input logic brk, input logic ferr, input logic perr,
                                  input logic [8:0] d);
        return {brk, ferr, perr, d};
    endfunction

    task automatic bit_time(input int inst, input logic v);
        #1;
        case (inst)
            0:       rx0 = v;
            1:       rx1 = v;
            default: rx2 = v;
        endcase
        repeat (CPB) @(posedge clk);
    endtask

    // par < 0 means no parity bit is sent.
    task automatic send(input int inst, input logic [8:0] data, input int nbits, input int par,
                        input logic s1, input logic s2, input int nstop);
        bit_time(inst, 1'b0);
        for (int i = 0; i < nbits; i++) bit_time(inst, data[i]);
        if (par >= 0) bit_time(inst, par[0]);
        bit_time(inst, s1);
        if (nstop == 2) bit_time(inst, s2);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 400 && (q0.size() + q1.size() + q2.size()) != 0; i++) begin
            @(posedge clk);
            #1;
        end
        check("scoreboard_drain", q0.size() + q1.size() + q2.size(), 0);
    endtask

    always @(negedge clk) begin
        if (busy_chk0) begin
            busy_chk0 = 1'b0;
            check("busy_low_after_cleanup0", busy0, 0);
        end
        if (dv0) begin
            dv_cnt0++;
            if (hold) begin
                hold_cnt++;
                if (hold_cnt == 1) hold_first = pack(brk0, ferr0, perr0, {1'b0, d0});
                check("hold_break_flag", brk0, BRK_EXP);
            end else if (q0.size() == 0) begin
                check("unexpected_dv0", q0.size(), 1);
            end else begin
                e0 = q0.pop_front();
                check("frame_8n1", pack(brk0, ferr0, perr0, {1'b0, d0}), e0);
                busy_chk0 = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (dv1) begin
            if (q1.size() == 0) begin
                check("unexpected_dv1", q1.size(), 1);
            end else begin
                e1 = q1.pop_front();
                check("frame_7e1", pack(brk1, ferr1, perr1, {2'b0, d1}), e1);
            end
        end
    end

    always @(negedge clk) begin
        if (dv2) begin
            if (q2.size() == 0) begin
                check("unexpected_dv2", q2.size(), 1);
            end else begin
                e2 = q2.pop_front();
                check("frame_8o2", pack(brk2, ferr2, perr2, {1'b0, d2}), e2);
            end
        end
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_dv0", dv0, 0);
        check("rst_data0", d0, 0);
        check("rst_perr0", perr0, 0);
        check("rst_ferr0", ferr0, 0);
        check("rst_busy0", busy0, 0);
        check("rst_break0", brk0, 0);
        check("rst_data1", d1, 0);
        check("rst_busy2", busy2, 0);
        rst = 1'b0;
        @(posedge clk);

        // 8N1 0xA5
        q0.push_back(pack(1'b0, 1'b0, 1'b0, 9'h0A5));
        send(0, 9'h0A5, 8, -1, 1'b1, 1'b1, 1);
        wait_drain();
        repeat (2) @(posedge clk);
        #1;
        check("idle_after_frame0", busy0, 0);

        // 7E1 0x35: four ones, so parity 0 is correct and parity 1 is an error
        q1.push_back(pack(1'b0, 1'b0, 1'b0, 9'h035));
        send(1, 9'h035, 7, 0, 1'b1, 1'b1, 1);
        q1.push_back(pack(1'b0, 1'b0, 1'b1, 9'h035));
        send(1, 9'h035, 7, 1, 1'b1, 1'b1, 1);
        wait_drain();

        // 8O2: 0x00 with correct parity but second stop low, then 0xFF back-to-back
        q2.push_back(pack(1'b0, 1'b1, 1'b0, 9'h000));
        send(2, 9'h000, 8, 1, 1'b1, 1'b0, 2);
        q2.push_back(pack(1'b0, 1'b0, 1'b0, 9'h0FF));
        send(2, 9'h0FF, 8, 1, 1'b1, 1'b1, 2);
        wait_drain();
        repeat (2) @(posedge clk);
        #1;
        check("idle_after_frame2", busy2, 0);

        // Start-bit glitch of 6 clocks
        saved = dv_cnt0;
        @(posedge clk);
        #1 rx0 = 1'b0;
        repeat (6) @(posedge clk);
        #1 rx0 = 1'b1;
        check("glitch_busy_high", busy0, 1);
        for (int i = 0; i < HALF + 3 && busy0; i++) begin
            @(posedge clk);
            #1;
        end
        check("glitch_busy_low", busy0, 0);
        repeat (40) @(posedge clk);
        #1;
        check("glitch_no_dv", dv_cnt0, saved);

        // Reset during data bit 4 of 0x5A
        saved = dv_cnt0;
        @(posedge clk);
        bit_time(0, 1'b0);
        for (int i = 0; i < 4; i++) bit_time(0, (i % 2) == 1);
        #1 rx0 = 1'b1;
        repeat (8) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("midrst_dv0", dv0, 0);
        check("midrst_data0", d0, 0);
        check("midrst_ferr0", ferr0, 0);
        check("midrst_busy0", busy0, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2 * CPB) @(posedge clk);
        #1;
        check("midrst_no_dv", dv_cnt0, saved);
        q0.push_back(pack(1'b0, 1'b0, 1'b0, 9'h03C));
        send(0, 9'h03C, 8, -1, 1'b1, 1'b1, 1);
        wait_drain();

        // Line held low for 20 bit times
        hold     = 1'b1;
        hold_cnt = 0;
        @(posedge clk);
        #1 rx0 = 1'b0;
        repeat (20 * CPB) @(posedge clk);
`ifdef UART_RX_BREAK_DETECT_EN
        check("break_busy_held", busy0, 1);
`endif
        #1 rx0 = 1'b1;
        repeat (200) @(posedge clk);
        #1;
        hold = 1'b0;
        check("hold_first_frame", hold_first, pack(BRK_EXP, 1'b1, 1'b0, 9'h000));
        check("idle_after_hold", busy0, 0);
`ifdef UART_RX_BREAK_DETECT_EN
        check("break_single_dv", hold_cnt, 1);
`else
        check("held_low_multi_dv", hold_cnt >= 2, 1);
`endif

        check("queues_empty", q0.size() + q1.size() + q2.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
